m_lsu: RTL

Parametrised memory-stage load/store unit for the pipelined MIPS core. It takes the M-stage store/load operation codes, address and write data, and runs a request/acknowledge transaction on the data bus with variable wait states. It generates lane-aligned byte enables and store data, and returns the sign- or zero-extended load result. It detects misaligned accesses (AdEL/AdES) and bus errors or timeouts, and holds the pipeline with `stall` until the access completes.

---
 rtl/m_lsu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/m_lsu.sv
// Memory-stage load/store unit: aligned request/acknowledge bus access with
// lane steering, load extension, misalignment and bus-error/timeout reporting.
module m_lsu #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [2:0]          mem_store_op,
  input  logic [2:0]          mem_load_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                flush,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic                exc_bus,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;

  logic              is_store, is_load, misaligned, accept;
  logic [3:0]        size;
  logic [OFF-1:0]    off_p0;
  logic [NB-1:0]     be_base, be_p0;

  logic [ADDR_W-1:0] addr_p1;
  logic [NB-1:0]     be_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              we_p1;
  logic [2:0]        op_p1;
  logic [OFF-1:0]    off_p1;

  logic [7:0]        wait_cnt;
  logic              err_q, kill_q;
  logic [DATA_W-1:0] shifted, rdata_p2;

  // Extension of a lane-justified load; lw sign-extends only matters on a 64-bit bus.
  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (op)
      3'b000:  r = DATA_W'($signed(d[31:0]));
      3'b001:  r = DATA_W'($signed(d[15:0]));
      3'b010:  r = DATA_W'($signed(d[7:0]));
      3'b011:  r = DATA_W'(d[15:0]);
      3'b100:  r = DATA_W'(d[7:0]);
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    is_store = 1'b0;
    is_load  = 1'b0;
    size     = 4'd0;
    if (mem_store_op != 3'b000) begin
      case (mem_store_op)
        3'b001:  begin is_store = 1'b1; size = 4'd1; end
        3'b010:  begin is_store = 1'b1; size = 4'd2; end
        3'b011:  begin is_store = 1'b1; size = 4'd4; end
        3'b100:  if (DATA_W == 64) begin is_store = 1'b1; size = 4'd8; end
        default: ;
      endcase
    end else begin
      case (mem_load_op)
        3'b000:  begin is_load = 1'b1; size = 4'd4; end
        3'b001:  begin is_load = 1'b1; size = 4'd2; end
        3'b010:  begin is_load = 1'b1; size = 4'd1; end
        3'b011:  begin is_load = 1'b1; size = 4'd2; end
        3'b100:  begin is_load = 1'b1; size = 4'd1; end
        3'b101:  if (DATA_W == 64) begin is_load = 1'b1; size = 4'd8; end
        default: ;
      endcase
    end
  end

  assign off_p0     = addr[OFF-1:0];
  assign misaligned = |(4'(off_p0) & (size - 4'd1));

  always_comb begin
    be_base = '0;
    for (int i = 0; i < NB; i++) be_base[i] = (i < int'(size));
    be_p0 = be_base << off_p0;
  end

  assign shifted = bus_rdata >> {off_p1, 3'b000};

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    exc_bus   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    case (state)
      IDLE: begin
        // Outputs stay quiet while reset is held, even with a request present.
        if (reset && req_valid && (is_store || is_load) && !flush) begin
          if (misaligned) begin
            done     = 1'b1;
            exc_adel = is_load;
            exc_ades = is_store;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        bus_req   = 1'b1;
        stall     = 1'b1;
        bus_we    = we_p1;
        bus_addr  = addr_p1;
        bus_be    = be_p1;
        bus_wdata = wdata_p1;
        if (bus_ack || wait_cnt == LAST_WAIT) state_n = RESP;
      end
      RESP: begin
        done    = !kill_q;
        exc_bus = err_q && !kill_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture (p1): held stable for the whole bus transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= {addr[ADDR_W-1:OFF], {OFF{1'b0}}};
      be_p1    <= be_p0;
      wdata_p1 <= wdata << {off_p0, 3'b000};
      we_p1    <= is_store;
      op_p1    <= mem_load_op;
      off_p1   <= off_p0;
    end
  end

  // Response capture (p2) and transaction control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      rdata_p2 <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          wait_cnt <= 8'd0;
          err_q    <= 1'b0;
          kill_q   <= 1'b0;
        end
        BUSY: begin
          if (flush) kill_q <= 1'b1;
          if (bus_ack) begin
            err_q    <= bus_err;
            rdata_p2 <= (we_p1 || bus_err) ? '0 : load_ext(op_p1, shifted);
          end else if (wait_cnt == LAST_WAIT) begin
            err_q    <= 1'b1;
            rdata_p2 <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_p2;

endmodule
